mips_prog_loader: RTL and testbench

Parametrised instruction-memory loader for the MIPS processor. It accepts a program as a valid/ready word stream, writes it into instruction memory through the processor's `init`/`init_addr`/`init_data` port, and checks an appended checksum. It holds the core in reset until a load succeeds, then releases it. It replaces hand-driven `init` sequencing and adds length checking, reload and error reporting.

---
 rtl/mips_loader_pkg.sv | 21 ++
 rtl/mips_prog_loader.sv | 98 +++++++++
 tb/tb_mips_prog_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_loader_pkg.sv
// Shared types for the MIPS instruction-memory loader: FSM state encoding
// and the program-length range check.
package mips_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        FAIL  = 3'd4
    } state_t;

    // Smallest program the loader will accept; an empty load is an error.
    localparam int unsigned MIN_PROG_LEN = 1;

    // A requested length is usable when it is non-empty and fits in memory.
    function automatic logic len_in_range(input int unsigned len, input int unsigned depth);
        return (len >= MIN_PROG_LEN) && (len <= depth);
    endfunction

endpackage

// File: rtl/mips_prog_loader.sv
// Streams a program into MIPS instruction memory over the init port,
// verifies an optional trailing checksum, and holds the core in reset
// until a load has succeeded.
module mips_prog_loader
    import mips_loader_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 8,
    parameter int unsigned DEPTH    = 256,
    parameter bit          CHECKSUM = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              init,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    state_t            state;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] sum;
    logic              hs;
    logic              len_ok;
    logic              last_word;

    assign hs        = s_valid && s_ready;
    assign len_ok    = len_in_range(32'(prog_len), DEPTH);
    assign last_word = ((count + 1'b1) == len);

    // Status outputs depend only on the registered state, never on s_valid.
    assign s_ready      = (state == LOAD) || (state == CHECK);
    assign busy         = s_ready;
    assign core_reset   = (state != RUN);
    assign done         = (state == RUN);
    assign error        = (state == FAIL);
    // The write pointer doubles as the accepted-word count.
    assign words_loaded = count;

    // Load FSM with registered memory-write port, checksum accumulator and word count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            len       <= '0;
            count     <= '0;
            sum       <= '0;
            init      <= 1'b0;
            init_addr <= '0;
            init_data <= '0;
        end else begin
            init <= 1'b0;
            case (state)
                // Idle, running and failed all react to start the same way.
                IDLE, RUN, FAIL: begin
                    if (start) begin
                        if (len_ok) begin
                            len   <= prog_len;
                            count <= '0;
                            sum   <= '0;
                            state <= LOAD;
                        end else begin
                            state <= FAIL;
                        end
                    end
                end
                LOAD: begin
                    if (hs) begin
                        init      <= 1'b1;
                        // count < len <= DEPTH, so the truncation never wraps.
                        init_addr <= count[ADDR_W-1:0];
                        init_data <= s_data;
                        sum       <= sum + s_data;
                        count     <= count + 1'b1;
                        if (last_word)
                            state <= CHECKSUM ? CHECK : RUN;
                    end
                end
                // The checksum word is compared against the running sum, not stored.
                CHECK: begin
                    if (hs)
                        state <= (s_data == sum) ? RUN : FAIL;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: a transaction-level reference model
// checked every cycle, plus literal expectations at key points.
module tb_mips_prog_loader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   prog_len;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready, init, core_reset, busy, done, error;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;
    logic [ADDR_W:0]   words_loaded;

    int n_checks = 0;
    int n_errors = 0;

    mips_prog_loader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CHECKSUM(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .init(init), .init_addr(init_addr), .init_data(init_data),
        .core_reset(core_reset), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // Loader is "taking words" while m_busy; the first m_len words are
    // written, the one after them is the checksum.
    logic              m_busy, m_done, m_err, m_init;
    logic [ADDR_W:0]   m_len, m_wl;
    logic [DATA_W-1:0] m_sum, m_data;
    logic [ADDR_W-1:0] m_addr;
    bit                chk_en = 1'b0;

    always @(posedge clk) begin
        m_init <= 1'b0;
        if (reset) begin
            m_busy <= 0; m_done <= 0; m_err <= 0;
            m_len <= '0; m_wl <= '0; m_sum <= '0; m_addr <= '0; m_data <= '0;
        end else if (m_busy) begin
            if (s_valid) begin
                if (m_wl < m_len) begin
                    m_init <= 1'b1;
                    m_addr <= m_wl[ADDR_W-1:0];
                    m_data <= s_data;
                    m_sum  <= m_sum + s_data;
                    m_wl   <= m_wl + 1'b1;
                end else begin
                    m_busy <= 1'b0;
                    if (s_data == m_sum) m_done <= 1'b1;
                    else                 m_err  <= 1'b1;
                end
            end
        end else if (start) begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (prog_len >= 1 && prog_len <= DEPTH) begin
                m_busy <= 1'b1; m_len <= prog_len; m_wl <= '0; m_sum <= '0;
            end else begin
                m_err <= 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_ready",      s_ready,      m_busy);
            chk("busy",         busy,         m_busy);
            chk("done",         done,         m_done);
            chk("error",        error,        m_err);
            chk("core_reset",   core_reset,   !m_done);
            chk("init",         init,         m_init);
            chk("init_addr",    init_addr,    m_addr);
            chk("init_data",    init_data,    m_data);
            chk("words_loaded", words_loaded, m_wl);
        end
    end

    // Write log and ready monitor for directed checks.
    int wlog[$];
    int rdy_seen = 0;
    always @(negedge clk) begin
        if (init) wlog.push_back(int'(init_addr));
        if (s_ready) rdy_seen++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_start(input int len);
        start = 1'b1;
        prog_len = (ADDR_W+1)'(len);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one word and hold it until a handshake edge has passed.
    task automatic send(input logic [DATA_W-1:0] w);
        bit rdy;
        bit ok = 0;
        s_valid = 1'b1;
        s_data  = w;
        for (int i = 0; i < 2000; i++) begin
            rdy = s_ready;
            @(negedge clk);
            if (rdy) begin ok = 1; break; end
        end
        s_valid = 1'b0;
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL send_timeout: got no handshake expected handshake for %h", w);
        end
    endtask

    logic [DATA_W-1:0] prog3 [3] = '{32'h8C010004, 32'hAC020008, 32'h2001000A};

    initial begin
        logic [DATA_W-1:0] acc;
        logic [DATA_W-1:0] w;
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] acc;
        logic [DATA_W-1:0] w;
        bit ordered;
        reset = 1'b1; start = 1'b0; prog_len = '0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset state
        chk("rst_s_ready", s_ready, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_words_loaded", words_loaded, 0);
        chk("rst_init_data", init_data, 0);
        @(negedge clk);

        // Good load: 3 words, checksum = sum mod 2**32 = 0x58040016
        wlog.delete();
        do_start(3);
        chk("load_s_ready", s_ready, 1);
        for (int i = 0; i < 3; i++) send(prog3[i]);
        chk("model_sum", m_sum, 32'h58040016);
        send(32'h58040016);
        chk("good_done", done, 1);
        chk("good_core_reset", core_reset, 0);
        chk("good_words", words_loaded, 3);
        chk("good_nwrites", wlog.size(), 3);
        for (int i = 0; i < 3 && i < wlog.size(); i++) chk("good_addr", wlog[i], i);
        @(negedge clk);

        // Bad checksum (reload from RUN also exercised here)
        wlog.delete();
        do_start(3);
        chk("reload_core_reset", core_reset, 1);
        chk("reload_done", done, 0);
        for (int i = 0; i < 3; i++) send(prog3[i]);
        send(32'h00000000);
        chk("bad_error", error, 1);
        chk("bad_core_reset", core_reset, 1);
        @(negedge clk);
        chk("bad_nwrites", wlog.size(), 3);

        // Length errors
        rdy_seen = 0;
        do_start(0);
        chk("len0_error", error, 1);
        @(negedge clk);
        do_start(DEPTH + 1);
        chk("lenbig_error", error, 1);
        @(negedge clk);
        chk("len_no_ready", rdy_seen, 0);

        // Full depth with random valid gaps
        wlog.delete();
        acc = '0;
        do_start(DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            while ($urandom_range(0, 2) == 0) @(negedge clk);
            w = $urandom;
            acc += w;
            send(w);
        end
        @(negedge clk);
        send(acc);
        chk("full_done", done, 1);
        chk("full_words", words_loaded, DEPTH);
        chk("full_nwrites", wlog.size(), DEPTH);
        if (wlog.size() > 0) chk("full_last_addr", wlog[wlog.size()-1], DEPTH - 1);
        ordered = 1;
        for (int i = 0; i < wlog.size(); i++) if (wlog[i] != i) ordered = 0;
        chk("full_order", ordered, 1);

        // Reload from RUN with a single word
        wlog.delete();
        do_start(1);
        chk("rl1_core_reset", core_reset, 1);
        chk("rl1_done", done, 0);
        send(32'h12345678);
        send(32'h12345678);
        chk("rl1_done_again", done, 1);
        chk("rl1_nwrites", wlog.size(), 1);
        if (wlog.size() > 0) chk("rl1_addr", wlog[0], 0);
        @(negedge clk);

        // Reset mid-load after 2 of 5 words
        do_start(5);
        send(32'h11111111);
        send(32'h22222222);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mr_s_ready", s_ready, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_error", error, 0);
        chk("mr_init", init, 0);
        chk("mr_init_addr", init_addr, 0);
        chk("mr_init_data", init_data, 0);
        chk("mr_core_reset", core_reset, 1);
        chk("mr_words", words_loaded, 0);
        wlog.delete();
        do_start(2);
        send(32'h00000005);
        send(32'h00000007);
        send(32'h0000000C);
        chk("mr_reload_done", done, 1);
        chk("mr_nwrites", wlog.size(), 2);
        if (wlog.size() > 1) begin
            chk("mr_addr0", wlog[0], 0);
            chk("mr_addr1", wlog[1], 1);
        end
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
